// File: rtl/mult_pkg.sv
// Shared widths, alignment shifts and FSM encoding for the 7x7 Booth multiplier datapath.
package mult_pkg;

  localparam int unsigned PP00_W     = 11;
  localparam int unsigned PP01_W     = 12;
  localparam int unsigned PP02_W     = 12;
  localparam int unsigned PP03_W     = 10;
  localparam int unsigned PROD_W     = 14;
  localparam int unsigned PP02_SHIFT = 2;
  localparam int unsigned PP03_SHIFT = 4;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_e;

  // Partial products held for the ACC steps; pp00 goes straight into the accumulator.
  typedef struct packed {
    logic [PP01_W-1:0] pp01;
    logic [PP02_W-1:0] pp02;
    logic [PP03_W-1:0] pp03;
  } pp_latch_t;

endpackage

// File: rtl/pp_align_7x7.sv
// Selects the latched partial product for the current ACC step and aligns it to its weight.
module pp_align_7x7
  import mult_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic [CNT_W-1:0] cnt,
  input  pp_latch_t        pps,
  output logic [ACC_W-1:0] addend_c
);

  // cnt=0 never occurs in ACC; it contributes nothing.
  always_comb begin
    addend_c = '0;
    case (cnt)
      CNT_W'(1): addend_c = ACC_W'(pps.pp01);
      CNT_W'(2): addend_c = ACC_W'(pps.pp02) << PP02_SHIFT;
      CNT_W'(3): addend_c = ACC_W'(pps.pp03) << PP03_SHIFT;
      default:   addend_c = '0;
    endcase
  end

endmodule

// File: rtl/pp_accumulator_7x7.sv
// Iterative partial-product accumulator: one aligned addend per cycle, result held on a
// valid/ready output until consumed.
module pp_accumulator_7x7
  import mult_pkg::PP00_W, mult_pkg::PP01_W, mult_pkg::PP02_W, mult_pkg::PP03_W,
         mult_pkg::CNT_W, mult_pkg::pp_latch_t, mult_pkg::IDLE, mult_pkg::ACC, mult_pkg::HOLD;
#(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned PROD_W = mult_pkg::PROD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PP00_W-1:0] pp00,
  input  logic [PP01_W-1:0] pp01,
  input  logic [PP02_W-1:0] pp02,
  input  logic [PP03_W-1:0] pp03,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic [1:0]        out_carry
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_ACC  = 2'(ACC);
  localparam logic [1:0] ST_HOLD = 2'(HOLD);

  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] addend_c;
  pp_latch_t        pps_q;
  logic             load_c;
  logic             done_c;
  logic             drain_c;

  pp_align_7x7 #(
    .ACC_W (ACC_W)
  ) u_align (
    .cnt      (cnt_q),
    .pps      (pps_q),
    .addend_c (addend_c)
  );

  // A held result frees the block in the same cycle it is taken, so back-to-back jobs chain.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    acc_nxt   = acc_q;
    load_c    = 1'b0;
    done_c    = 1'b0;
    drain_c   = 1'b0;
    if (clear) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      acc_nxt   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) load_c = 1'b1;
        end
        ST_ACC: begin
          acc_nxt = acc_q + addend_c;
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(3)) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
            done_c    = 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            drain_c = 1'b1;
            if (in_valid) load_c = 1'b1;
            else          state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      // pp00 seeds the accumulator directly, saving one add step.
      if (load_c) begin
        state_nxt = ST_ACC;
        cnt_nxt   = CNT_W'(1);
        acc_nxt   = ACC_W'(pp00);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      pps_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      acc_q <= acc_nxt;
      if (load_c) pps_q <= {pp01, pp02, pp03};
    end
  end

  // Result registers capture the final sum on the last ACC edge so out_valid is not delayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_carry <= '0;
    end else begin
      if (clear)        out_valid <= 1'b0;
      else if (done_c)  out_valid <= 1'b1;
      else if (drain_c) out_valid <= 1'b0;
      if (done_c) begin
        out_prod  <= acc_nxt[PROD_W-1:0];
        out_carry <= acc_nxt[PROD_W+1:PROD_W];
      end
    end
  end

endmodule

// File: tb/tb_pp_accumulator_7x7.sv
// Directed and randomised checks of pp_accumulator_7x7 with hand-computed expected sums.
module tb_pp_accumulator_7x7;

  localparam int NJOBS = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] pp00;
  logic [11:0] pp01;
  logic [11:0] pp02;
  logic [9:0]  pp03;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_prod;
  logic [1:0]  out_carry;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  pp_accumulator_7x7 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp00      (pp00),
    .pp01      (pp01),
    .pp02      (pp02),
    .pp03      (pp03),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns #1 after the accepting posedge with in_valid dropped.
  task automatic send(input logic [10:0] a, input logic [11:0] b,
                      input logic [11:0] c, input logic [9:0] d);
    int n;
    pp00 = a; pp01 = b; pp02 = c; pp03 = d;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("in_ready_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input logic [13:0] prod, input logic [1:0] carry);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_prod"}, 32'(out_prod), 32'(prod));
    chk({tag, "_carry"}, 32'(out_carry), 32'(carry));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pp00 = '0; pp01 = '0; pp02 = '0; pp03 = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_prod", 32'(out_prod), 32'd0);
    chk("rst_carry", 32'(out_carry), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Job 1 then job 2
    send(11'h300, 12'h800, 12'h800, 10'h000);
    wait_valid("job1", 14'h2B00, 2'd0);
    consume();
    send(11'h7FF, 12'hFFF, 12'hFFF, 10'h3FF);
    wait_valid("job2", 14'h17EA, 2'd2);

    // Backpressure: result must hold steady
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_stable", 32'({out_valid, out_carry, out_prod}), 32'({1'b1, 2'd2, 14'h17EA}));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send(11'h300, 12'h800, 12'h800, 10'h000);
    wait_valid("chain", 14'h2B00, 2'd0);
    consume();

    // Async reset in the middle of accumulation
    send(11'h7FF, 12'hFFF, 12'hFFF, 10'h3FF);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_prod", 32'(out_prod), 32'd0);
    chk("async_carry", 32'(out_carry), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(11'h7FF, 12'hFFF, 12'hFFF, 10'h3FF);
    wait_valid("post_rst", 14'h17EA, 2'd2);
    consume();

    // Clear during ACC drops the job
    send(11'h7FF, 12'hFFF, 12'hFFF, 10'h3FF);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_acc_valid", 32'(out_valid), 32'd0);
    chk("clr_acc_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("clr_acc_dropped", 32'(out_valid), 32'd0);

    // Clear during HOLD beats a simultaneous handshake
    send(11'h300, 12'h800, 12'h800, 10'h000);
    wait_valid("pre_clr", 14'h2B00, 2'd0);
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    pp00 = 11'h7FF; pp01 = 12'hFFF; pp02 = 12'hFFF; pp03 = 10'h3FF;
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("clr_hold_valid", 32'(out_valid), 32'd0);
    chk("clr_hold_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("clr_no_accept", 32'(out_valid), 32'd0);
    send(11'h001, 12'h002, 12'h001, 10'h001);
    wait_valid("job5", 14'h0017, 2'd0);
    consume();

    // Random jobs with stalls on both sides
    fork
      begin : driver
        int guard;
        int s;
        @(negedge clk); #1;
        for (int j = 0; j < NJOBS; j++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk); #1;
          end
          pp00 = 11'($urandom); pp01 = 12'($urandom);
          pp02 = 12'($urandom); pp03 = 10'($urandom);
          in_valid = 1'b1;
          guard = 0;
          while (!in_ready && guard < 100) begin
            @(negedge clk); #1; guard++;
          end
          s = (int'(pp00) + int'(pp01) + int'(pp02) * 4 + int'(pp03) * 16) % 65536;
          exp_q.push_back(16'(s));
          @(negedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int rcv;
        int cyc;
        logic [15:0] e;
        rcv = 0; cyc = 0;
        while (rcv < NJOBS && cyc < 80000) begin
          @(negedge clk); cyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra: observed=0x%0h expected=none", {out_carry, out_prod});
              end
            end else begin
              e = exp_q.pop_front();
              chk("sb_result", 32'({out_carry, out_prod}), 32'(e));
            end
            rcv++;
          end
        end
        out_ready = 1'b0;
        chk("sb_count", 32'(rcv), 32'(NJOBS));
      end
    join
    @(negedge clk);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
